// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter
//   Two-master AHB arbiter in front of a single bridge slave. Grants the bus
//   to one master at a time, keeps bursts atomic, and rotates ownership
//   under contention once the owner has had MAX_HOLD accepted transfers.
//
// Ports
//   hclk, hreset              clock, synchronous active-high reset
//   mX_hbusreq/htrans/haddr/hwrite/hwdata  master X request and transfer
//   mX_hgrant                 registered grant to master X
//   hmaster                   current address-phase owner
//   hready, hrdata_m          broadcast ready / read data back to masters
//   htrans/haddr/hwrite/hwdata  muxed transfer towards the bridge
//   hreadyin                  HREADY into the bridge
//   hr_readyout, hrdata       bridge ready and read data
module ahb_bridge_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        m0_hbusreq,
  input  logic        m1_hbusreq,
  input  logic [1:0]  m0_htrans,
  input  logic [1:0]  m1_htrans,
  input  logic [31:0] m0_haddr,
  input  logic [31:0] m1_haddr,
  input  logic        m0_hwrite,
  input  logic        m1_hwrite,
  input  logic [31:0] m0_hwdata,
  input  logic [31:0] m1_hwdata,
  output logic        m0_hgrant,
  output logic        m1_hgrant,
  output logic        hmaster,
  output logic        hready,
  output logic [31:0] hrdata_m,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [31:0] hwdata,
  output logic        hreadyin,
  input  logic        hr_readyout,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     state;
  state_t     next_state;
  logic       last_owner;
  logic       downer;
  logic       dvalid;
  logic [7:0] hold_cnt;

  logic       owned;
  logic       owner;
  logic       owner_req;
  logic       other_req;
  logic [1:0] owner_trans;
  logic       accept;
  logic       preempt;
  logic       handover;

  assign accept      = hr_readyout;
  assign owned       = (state != IDLE);
  assign owner       = (state == OWN1);
  assign owner_req   = owner ? m1_hbusreq : m0_hbusreq;
  assign other_req   = owner ? m0_hbusreq : m1_hbusreq;
  assign owner_trans = owner ? m1_htrans  : m0_htrans;
  assign preempt     = owned & other_req & (hold_cnt >= HOLD_MAX);
  // Ownership may only move at an accepted edge where the owner is idle,
  // so a burst (including BUSY beats and wait states) is never split.
  assign handover    = owned & accept & (owner_trans == 2'b00) &
                       (~owner_req | preempt);

  // State register
  always_ff @(posedge hclk) begin
    if (hreset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0_hbusreq && m1_hbusreq) next_state = last_owner ? OWN0 : OWN1;
        else if (m0_hbusreq)          next_state = OWN0;
        else if (m1_hbusreq)          next_state = OWN1;
      end
      OWN0, OWN1: begin
        if (handover) begin
          if (other_req)      next_state = owner ? OWN0 : OWN1;
          else if (owner_req) next_state = state;
          else                next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic: address-phase mux, data-phase mux, pass-throughs
  always_comb begin
    htrans   = 2'b00;
    haddr    = '0;
    hwrite   = 1'b0;
    if (owned) begin
      htrans = owner_trans;
      haddr  = owner ? m1_haddr  : m0_haddr;
      hwrite = owner ? m1_hwrite : m0_hwrite;
    end
    hwdata   = dvalid ? (downer ? m1_hwdata : m0_hwdata) : '0;
    hready   = hr_readyout;
    hreadyin = hr_readyout;
    hrdata_m = hrdata;
  end

  // Grants, owner bookkeeping, hold counter and data-phase tracking
  always_ff @(posedge hclk) begin
    if (hreset) begin
      last_owner <= 1'b1;
      hmaster    <= 1'b0;
      m0_hgrant  <= 1'b0;
      m1_hgrant  <= 1'b0;
      downer     <= 1'b0;
      dvalid     <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      if (next_state != IDLE && next_state != state) begin
        last_owner <= (next_state == OWN1);
        hmaster    <= (next_state == OWN1);
      end
      // Grant is withdrawn while the owner is being pre-empted but still
      // finishing its current transfer.
      m0_hgrant <= (next_state == OWN0) & ~((state == OWN0) & preempt);
      m1_hgrant <= (next_state == OWN1) & ~((state == OWN1) & preempt);

      if (next_state == IDLE || next_state != state)
        hold_cnt <= '0;
      else if (accept && htrans[1] && hold_cnt < HOLD_MAX)
        hold_cnt <= hold_cnt + 8'd1;

      if (accept) begin
        downer <= hmaster;
        dvalid <= htrans[1] & owned;
      end
    end
  end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// tb_ahb_bridge_arbiter
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A behavioural model tracks the owner and data phase and is
//   compared against every DUT output on each falling edge.
module tb_ahb_bridge_arbiter;

  localparam int unsigned MAXH = 4;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        m0_hbusreq, m1_hbusreq;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] m0_haddr, m1_haddr;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hgrant, m1_hgrant;
  logic        hmaster, hready, hwrite, hreadyin, hr_readyout;
  logic [31:0] hrdata_m, haddr, hwdata, hrdata;
  logic [1:0]  htrans;

  always #5 hclk = ~hclk;

  ahb_bridge_arbiter #(.MAX_HOLD(MAXH)) dut (
    .hclk(hclk), .hreset(hreset),
    .m0_hbusreq(m0_hbusreq), .m1_hbusreq(m1_hbusreq),
    .m0_htrans(m0_htrans), .m1_htrans(m1_htrans),
    .m0_haddr(m0_haddr), .m1_haddr(m1_haddr),
    .m0_hwrite(m0_hwrite), .m1_hwrite(m1_hwrite),
    .m0_hwdata(m0_hwdata), .m1_hwdata(m1_hwdata),
    .m0_hgrant(m0_hgrant), .m1_hgrant(m1_hgrant),
    .hmaster(hmaster), .hready(hready), .hrdata_m(hrdata_m),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
    .hreadyin(hreadyin), .hr_readyout(hr_readyout), .hrdata(hrdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner is -1 when nobody holds the bus.
  int owner_m = -1;
  int last_m  = 1;
  int hm_m    = 0;
  int dwn_m   = 0;
  bit dv_m    = 0;
  int hold_m  = 0;
  bit g_m [2];
  bit started = 0;

  always @(posedge hclk) begin
    bit         rq [2];
    logic [1:0] tr [2];
    logic [1:0] bus;
    int         nxt, x;
    bit         pre;
    rq[0] = m0_hbusreq; rq[1] = m1_hbusreq;
    tr[0] = m0_htrans;  tr[1] = m1_htrans;
    started = 1;
    if (hreset) begin
      owner_m = -1; last_m = 1; hm_m = 0; dwn_m = 0; dv_m = 0; hold_m = 0;
      g_m[0] = 0; g_m[1] = 0;
    end else begin
      pre = 0;
      bus = (owner_m < 0) ? 2'b00 : tr[owner_m];
      nxt = owner_m;
      if (owner_m < 0) begin
        if (rq[0] && rq[1]) nxt = 1 - last_m;
        else if (rq[0])     nxt = 0;
        else if (rq[1])     nxt = 1;
      end else begin
        x   = 1 - owner_m;
        pre = rq[x] && (hold_m >= int'(MAXH));
        if (hr_readyout && bus == 2'b00 && (!rq[owner_m] || pre))
          nxt = rq[x] ? x : (rq[owner_m] ? owner_m : -1);
      end
      if (hr_readyout) begin
        dwn_m = hm_m;
        dv_m  = bus[1] && (owner_m >= 0);
      end
      for (int i = 0; i < 2; i++)
        g_m[i] = (nxt == i) && !(owner_m == i && pre);
      if (nxt != owner_m || nxt < 0) hold_m = 0;
      else if (hr_readyout && bus[1] && hold_m < int'(MAXH)) hold_m++;
      if (nxt >= 0 && nxt != owner_m) begin
        last_m = nxt;
        hm_m   = nxt;
      end
      owner_m = nxt;
    end
  end

  always @(negedge hclk) begin
    logic [1:0]  e_tr;
    logic [31:0] e_ad, e_wd;
    logic        e_wr;
    if (started) begin
      e_tr = 2'b00; e_ad = '0; e_wr = 1'b0;
      if (owner_m == 0) begin e_tr = m0_htrans; e_ad = m0_haddr; e_wr = m0_hwrite; end
      if (owner_m == 1) begin e_tr = m1_htrans; e_ad = m1_haddr; e_wr = m1_hwrite; end
      e_wd = dv_m ? (dwn_m == 1 ? m1_hwdata : m0_hwdata) : 32'h0;
      check("m0_hgrant", {31'b0, m0_hgrant}, {31'b0, g_m[0]});
      check("m1_hgrant", {31'b0, m1_hgrant}, {31'b0, g_m[1]});
      check("hmaster",   {31'b0, hmaster},   32'(hm_m));
      check("htrans",    {30'b0, htrans},    {30'b0, e_tr});
      check("haddr",     haddr,              e_ad);
      check("hwrite",    {31'b0, hwrite},    {31'b0, e_wr});
      check("hwdata",    hwdata,             e_wd);
      check("hready",    {31'b0, hready},    {31'b0, hr_readyout});
      check("hreadyin",  {31'b0, hreadyin},  {31'b0, hr_readyout});
      check("hrdata_m",  hrdata_m,           hrdata);
    end
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_hbusreq = 0; m1_hbusreq = 0; m0_htrans = 2'b00; m1_htrans = 2'b00;
    m0_haddr = '0; m1_haddr = '0; m0_hwrite = 0; m1_hwrite = 0;
    m0_hwdata = '0; m1_hwdata = '0; hr_readyout = 1; hrdata = 32'h1234_5678;
  endtask

  task automatic do_reset();
    hreset = 1;
    step();
    hreset = 0;
  endtask

  initial begin
    hreset = 1;
    idle_inputs();

    // Reset held two cycles
    step(); step();
    @(negedge hclk);
    check("rst_g0", {31'b0, m0_hgrant}, 32'd0);
    check("rst_g1", {31'b0, m1_hgrant}, 32'd0);
    check("rst_htrans", {30'b0, htrans}, 32'd0);
    check("rst_haddr", haddr, 32'd0);
    check("rst_hwdata", hwdata, 32'd0);
    hreset = 0;

    // Single write by m0
    m0_hbusreq = 1;
    step();
    @(negedge hclk);
    check("sw_grant", {31'b0, m0_hgrant}, 32'd1);
    m0_htrans = 2'b10; m0_haddr = 32'h8000_0004; m0_hwrite = 1;
    @(negedge hclk);
    check("sw_haddr", haddr, 32'h8000_0004);
    check("sw_hwrite", {31'b0, hwrite}, 32'd1);
    step();
    m0_htrans = 2'b00; m0_hwdata = 32'hA5A5_0001; m0_hbusreq = 0; m0_hwrite = 0;
    @(negedge hclk);
    check("sw_hwdata", hwdata, 32'hA5A5_0001);
    step(); step();

    // Simultaneous requests after reset: m0 first, then m1
    idle_inputs();
    do_reset();
    m0_hbusreq = 1; m1_hbusreq = 1;
    step();
    @(negedge hclk);
    check("sim_g0", {31'b0, m0_hgrant}, 32'd1);
    check("sim_g1", {31'b0, m1_hgrant}, 32'd0);
    m0_hbusreq = 0;
    step();
    @(negedge hclk);
    check("sim_g1b", {31'b0, m1_hgrant}, 32'd1);
    check("sim_hmaster", {31'b0, hmaster}, 32'd1);

    // Burst atomicity with a two-cycle stall mid-burst
    idle_inputs();
    do_reset();
    m0_hbusreq = 1;
    step();
    m1_hbusreq = 1;
    m0_htrans = 2'b10; m0_haddr = 32'h0000_00A0;
    step();
    m0_htrans = 2'b11; m0_haddr = 32'h0000_00A4; hr_readyout = 0;
    step(); step();
    @(negedge hclk);
    check("burst_stall_haddr", haddr, 32'h0000_00A4);
    check("burst_stall_owner", {31'b0, hmaster}, 32'd0);
    hr_readyout = 1;
    step();
    m0_haddr = 32'h0000_00A8;
    step();
    m0_haddr = 32'h0000_00AC;
    @(negedge hclk);
    check("burst_owner", {31'b0, hmaster}, 32'd0);
    step();
    m0_htrans = 2'b00; m0_hbusreq = 0;
    step();
    @(negedge hclk);
    check("burst_handover", {31'b0, hmaster}, 32'd1);

    // Pre-emption after MAXH accepted transfers
    idle_inputs();
    do_reset();
    m0_hbusreq = 1; m1_hbusreq = 1;
    step();
    m0_htrans = 2'b10;
    for (int i = 0; i < 4; i++) begin
      m0_haddr = 32'h100 + 32'(i * 4);
      step();
    end
    m0_haddr = 32'h110;
    @(negedge hclk);
    check("pre_g0_still", {31'b0, m0_hgrant}, 32'd1);
    step();
    m0_htrans = 2'b00;
    @(negedge hclk);
    check("pre_g0_drop", {31'b0, m0_hgrant}, 32'd0);
    check("pre_owner0", {31'b0, hmaster}, 32'd0);
    step();
    @(negedge hclk);
    check("pre_g1", {31'b0, m1_hgrant}, 32'd1);
    check("pre_owner1", {31'b0, hmaster}, 32'd1);

    // Reset in the middle of a burst
    idle_inputs();
    do_reset();
    m0_hbusreq = 1;
    step();
    m0_htrans = 2'b10; m0_hwdata = 32'hDEAD_0001;
    step();
    m0_htrans = 2'b11;
    step();
    hreset = 1;
    step();
    @(negedge hclk);
    check("rmb_htrans", {30'b0, htrans}, 32'd0);
    check("rmb_g0", {31'b0, m0_hgrant}, 32'd0);
    check("rmb_hwdata", hwdata, 32'd0);
    hreset = 0;
    m0_hbusreq = 0; m0_htrans = 2'b00; m1_hbusreq = 1;
    step();
    @(negedge hclk);
    check("rmb_g1", {31'b0, m1_hgrant}, 32'd1);
    check("rmb_hmaster", {31'b0, hmaster}, 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      hreset      = ($urandom_range(0, 199) == 0);
      m0_hbusreq  = ($urandom_range(0, 9) < 7);
      m1_hbusreq  = ($urandom_range(0, 9) < 7);
      m0_htrans   = 2'($urandom_range(0, 3));
      m1_htrans   = 2'($urandom_range(0, 3));
      m0_haddr    = $urandom;
      m1_haddr    = $urandom;
      m0_hwrite   = 1'($urandom_range(0, 1));
      m1_hwrite   = 1'($urandom_range(0, 1));
      m0_hwdata   = $urandom;
      m1_hwdata   = $urandom;
      hr_readyout = ($urandom_range(0, 3) != 0);
      hrdata      = $urandom;
      step();
    end

    @(negedge hclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_bridge_arbiter.md
AHB_BRIDGE_ARBITER -- requirements
Module: ahb_bridge_arbiter

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 8, accepted transfers after which a contended owner is pre-empted (range 1-255).
REQ-002 SHALL have these ports (name  direction  width  meaning):
- hclk  in  1  single clock; all state on rising edge.
- hreset  in  1  synchronous, active-high reset.
- m0_hbusreq, m1_hbusreq  in  1  bus request from master 0/1.
- m0_htrans, m1_htrans  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- m0_haddr, m1_haddr  in  32  master address.
- m0_hwrite, m1_hwrite  in  1  master write strobe.
- m0_hwdata, m1_hwdata  in  32  master write data.
- m0_hgrant, m1_hgrant  out  1  registered grant to master 0/1.
- hmaster  out  1  current address-phase owner.
- hready  out  1  broadcast transfer-ready to both masters.
- hrdata_m  out  32  broadcast read data to masters.
- htrans, haddr, hwrite, hwdata  out  2/32/1/32  muxed transfer to Bridge_top.
- hreadyin  out  1  HREADY input to Bridge_top.
- hr_readyout  in  1  bridge ready.
- hrdata  in  32  bridge read data.

Function
REQ-003 SHALL implement FSM states IDLE, OWN0, OWN1, held in a register.
REQ-004 SHALL define "accept" as hr_readyout=1 on a rising edge.
REQ-005 In IDLE, SHALL go to OWN0 or OWN1 on any request:
- one request: grant that master;
- both requests: grant the master that is not last_owner; last_owner resets to 1, so m0 wins first.
REQ-006 In OWNx, SHALL hand over only on an edge with hr_readyout=1 and owner htrans=IDLE.
REQ-007 The handover condition SHALL be: owner hbusreq=0, or preempt=1 (other hbusreq=1 and hold_cnt>=MAX_HOLD).
REQ-008 On handover, the next state SHALL be:
- other master requesting: OWN(other);
- otherwise, owner hbusreq=1: stay in OWNx;
- otherwise: IDLE.
REQ-009 SHALL never change owner while owner htrans is NONSEQ, SEQ or BUSY, or while hr_readyout=0.
REQ-010 last_owner SHALL update on every entry to OWNx.
REQ-011 mX_hgrant SHALL be 1 in OWNx, except it SHALL drop to 0 one cycle after preempt first becomes 1 while the FSM stays in OWNx.
REQ-012 hmaster SHALL equal the owner index; in IDLE it SHALL hold its last value.
REQ-013 htrans/haddr/hwrite SHALL combinationally pass the owner's signals; in IDLE they SHALL be 00/0/0.
REQ-014 SHALL keep a data-phase register downer (1 bit) and dvalid (1 bit), updated on accept:
- downer <= hmaster;
- dvalid <= htrans[1] & FSM≠IDLE.
REQ-015 hwdata SHALL pass mX_hwdata selected by downer when dvalid=1, else 0.
REQ-016 hready and hreadyin SHALL equal hr_readyout; hrdata_m SHALL equal hrdata (pure pass-through, zero latency).
REQ-017 hold_cnt SHALL be 8 bits:
- cleared on each owner change and in IDLE;
- incremented on each accept with htrans[1]=1;
- saturating at MAX_HOLD.
REQ-018 Simultaneous hbusreq rise and handover SHALL resolve in the same edge with no extra idle cycle.
REQ-019 If hreset is asserted mid-burst, the burst SHALL be abandoned; bridge sees htrans=IDLE from the next cycle.

Reset
REQ-020 On hreset=1 at a rising edge, SHALL set: FSM=IDLE, last_owner=1, hmaster=0, m0_hgrant=m1_hgrant=0, downer=0, dvalid=0, hold_cnt=0.
REQ-021 During and after reset until first grant, outputs SHALL be htrans=00, haddr=0, hwrite=0, hwdata=0.
REQ-022 Reset SHALL take priority over all other transitions.

Verification
REQ-023 SHALL cover these directed scenarios (stimulus -> required response):
- Reset: hreset high 2 cycles -> grants 0, htrans=00, haddr=0, hwdata=0, FSM IDLE.
- Single write: m0_hbusreq=1 -> m0_hgrant=1 next edge; m0 NONSEQ haddr=0x8000_0004 -> bridge haddr=0x8000_0004, hwrite=1; hwdata=0xA5A5_0001 forwarded in following accepted cycle.
- Simultaneous requests after reset: both hbusreq=1 -> m0 granted first; m0 drops hbusreq with htrans=IDLE -> m1 granted next edge, hmaster=1.
- Burst atomicity: m0 INCR4 (NONSEQ,SEQ,SEQ,SEQ) with m1 requesting throughout and hr_readyout low 2 cycles mid-burst -> no owner change until m0 htrans=IDLE; haddr holds during stall.
- Pre-emption (MAX_HOLD=4): m0 keeps requesting through 5 single transfers, m1 requesting -> m0_hgrant drops after 4th accept; m1 owns after m0's next IDLE cycle.
- Reset mid-burst: hreset at 2nd SEQ -> next cycle htrans=00, grants 0, dvalid=0; subsequent m1-only request granted normally.
